uart_tx_fsm: RTL and testbench
==============================

// Module: uart_tx_fsm
// PURPOSE
//  UART transmitter: the serialising end of the UART_RX link. Latches a parallel word, emits
//  start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit on TX_OUT.
//  Bit period = prescale cycles of clk (same prescale bus as RX). Sits between the
//  system-side data producer and the serial line.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame
//  PRESCALE_W   6   width of prescale bus / bit-period counter
// PORTS
//  clk         in   1           single system clock, rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  P_DATA      in   DATA_WIDTH  parallel word to send
//  DATA_VALID  in   1           P_DATA valid; accepted only at an accept point (below)
//  PAR_EN      in   1           1 = append parity bit
//  PAR_TYP     in   1           0 = even, 1 = odd parity
//  prescale    in   PRESCALE_W  clk cycles per serial bit
//  TX_OUT      out  1           serial line, idles high; registered
//  busy        out  1           high while a frame is in flight; registered
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): TX_OUT=1, busy=0, state=IDLE, counters=0,
//    data/config latches cleared. Partial frame is abandoned; no resume.
//  - States: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE or START.
//  - Accept point: state==IDLE, or last cycle of STOP. DATA_VALID sampled only there;
//    DATA_VALID at any other time is ignored (no queueing, no error).
//  - On accept edge: latch P_DATA, PAR_EN, PAR_TYP, prescale; par = ^P_DATA ^ PAR_TYP;
//    next state START; TX_OUT<=0 and busy<=1 on that same edge (1-cycle latency from
//    DATA_VALID to start bit). Mid-frame input changes have no effect.
//  - Bit timer: edge_cnt counts 0..prescale_q-1 per bit; at prescale_q-1 it wraps to 0
//    and the FSM advances. Compare is modulo 2^PRESCALE_W: prescale=0 => 64-cycle bit.
//  - DATA: bit_cnt 0..DATA_WIDTH-1; TX_OUT = data_q[bit_cnt]; after bit DATA_WIDTH-1
//    go PARITY if PAR_EN latched, else STOP.
//  - PARITY: TX_OUT = par for one bit period. STOP: TX_OUT = 1 for one bit period.
//  - End of STOP: DATA_VALID=1 -> START directly (back-to-back, no idle gap, busy stays 1);
//    else IDLE, busy<=0 on the same edge TX_OUT stays 1.
//  - Frame length: (2 + DATA_WIDTH + PAR_EN) * prescale cycles of busy=1.
//  - TX_OUT is a flop output (glitch-free); TX_OUT driven only from FSM/datapath regs.
//  - Illegal state encodings recover to IDLE with TX_OUT=1, busy=0.
// STRUCTURE
//  - uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP, gray-style as RX),
//    PAR_EVEN=0/PAR_ODD=1, default DATA_WIDTH/PRESCALE_W. Shared with RX.
//  - Sub-module uart_tx_bit_timer: edge_cnt + bit_cnt, inputs clear/run/prescale_q,
//    outputs bit_done (edge_cnt==prescale_q-1) and last_data_bit.
//  - Top: FSM, data/config latches, parity reduce, TX_OUT/busy output regs.
// TESTING
//  - prescale=8, PAR_EN=1 even, P_DATA=0xA5 pulse -> TX_OUT 0,1,0,1,0,0,1,0,1,0(par),1,
//    each 8 cycles; busy high exactly 88 cycles; start bit 1 cycle after DATA_VALID.
//  - Same, PAR_TYP=1 -> parity bit 1; PAR_EN=0 -> no parity bit, busy 80 cycles.
//  - prescale=16, 0x00 then 0xFF, DATA_VALID held high -> second start bit immediately
//    after first stop bit, busy never drops between frames; DATA_VALID mid-frame ignored.
//  - Change P_DATA/prescale/PAR_EN mid-frame -> frame bits and timing unchanged.
//  - rst_n low during DATA bit 3 -> TX_OUT=1, busy=0 asynchronously; next DATA_VALID
//    yields a clean full frame.
//  - RX loopback: TX_OUT->RX_IN, random data, prescale in {8,16,32}, all parity modes ->
//    RX data_valid per frame, data matches, zero par/stop errors.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: state encodings, parity types, defaults.
// Used by both the TX and RX ends of the link.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PRESCALE_W_DEF = 6;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Neighbouring states differ in one bit
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b011,
      ST_PARITY = 3'b010,
      ST_STOP   = 3'b110
   } uart_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// UART TX bit timer: cycles-per-bit counter plus data bit index.
// bit_done marks the last clk cycle of the current serial bit.
module uart_tx_bit_timer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF,
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  run,
   input  logic                  data_en,
   input  logic [PRESCALE_W-1:0] prescale_q,
   output logic                  bit_done,
   output logic                  last_data_bit,
   output logic [BW-1:0]         bit_cnt
);

   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] edge_last;

   // Modulo compare: prescale 0 gives a full 2^PRESCALE_W period
   assign edge_last     = prescale_q - PRESCALE_W'(1);
   assign bit_done      = run && (edge_cnt == edge_last);
   assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clear) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (run) begin
         if (bit_done) begin
            edge_cnt <= '0;
            if (data_en)
               bit_cnt <= last_data_bit ? '0 : bit_cnt + BW'(1);
         end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop.
// Outputs are registered from the next-state decode.
module uart_tx_fsm
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  TX_OUT,
   output logic                  busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   uart_state_t state, state_nx;

   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_q;
   logic [PRESCALE_W-1:0] prescale_q;

   logic          accept;
   logic          tx_nx;
   logic          busy_nx;
   logic          bit_done;
   logic          last_data_bit;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_sel;

   uart_tx_bit_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (accept || (state_nx == ST_IDLE)),
      .run           (state != ST_IDLE),
      .data_en       (state == ST_DATA),
      .prescale_q    (prescale_q),
      .bit_done      (bit_done),
      .last_data_bit (last_data_bit),
      .bit_cnt       (bit_cnt)
   );

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (DATA_VALID) begin
               accept   = 1'b1;
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (bit_done)
               state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (bit_done && last_data_bit)
               state_nx = par_en_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_done)
               state_nx = ST_STOP;
         end
         ST_STOP: begin
            if (bit_done) begin
               if (DATA_VALID) begin
                  accept   = 1'b1;
                  state_nx = ST_START;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Index of the data bit that will be on the line after this edge
   always_comb begin
      bit_sel = bit_cnt;
      if (state == ST_DATA && bit_done)
         bit_sel = bit_cnt + BW'(1);
   end

   always_comb begin
      tx_nx   = 1'b1;
      busy_nx = (state_nx != ST_IDLE);
      case (state_nx)
         ST_START:  tx_nx = 1'b0;
         ST_DATA:   tx_nx = data_q[bit_sel];
         ST_PARITY: tx_nx = par_q;
         default:   tx_nx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         TX_OUT     <= 1'b1;
         busy       <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_q      <= 1'b0;
         prescale_q <= '0;
      end else begin
         state  <= state_nx;
         TX_OUT <= tx_nx;
         busy   <= busy_nx;
         if (accept) begin
            data_q     <= P_DATA;
            par_en_q   <= PAR_EN;
            par_q      <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            prescale_q <= prescale;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: directed and random frames checked per cycle
// against a line-level model of the expected serial waveform.
module tb_uart_tx_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] prescale;
   logic       TX_OUT;
   logic       busy;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic [5:0] ps;
   } cfg_t;

   uart_tx_fsm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic obs,
                      input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
      end
   endtask

   task automatic apply(input cfg_t c);
      P_DATA   = c.d;
      PAR_EN   = c.pe;
      PAR_TYP  = c.pt;
      prescale = c.ps;
   endtask

   task automatic launch(input cfg_t c);
      @(negedge clk);
      apply(c);
      DATA_VALID = 1'b1;
   endtask

   task automatic idle_chk(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   // Expected line: one entry per serial bit, each held p cycles
   task automatic frame(input cfg_t c, input bit noise,
                        input bit nv, input cfg_t n);
      int p, nb, tot;
      logic [10:0] bits;
      p   = (c.ps == 0) ? 64 : int'(c.ps);
      nb  = c.pe ? 11 : 10;
      tot = nb * p;
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++)
         bits[1+i] = c.d[i];
      if (c.pe)
         bits[9] = ($countones(c.d) % 2 == 1) ^ c.pt;
      for (int k = 0; k < tot; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("tx[%0d] d=%h", k, c.d), TX_OUT, bits[k/p]);
         chk($sformatf("busy[%0d] d=%h", k, c.d), busy, 1'b1);
         @(negedge clk);
         if (k + 1 < tot) begin
            DATA_VALID = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
               P_DATA   = 8'($urandom);
               PAR_EN   = 1'($urandom_range(0, 1));
               PAR_TYP  = 1'($urandom_range(0, 1));
               prescale = 6'($urandom);
            end
         end else if (nv) begin
            apply(n);
            DATA_VALID = 1'b1;
         end else begin
            DATA_VALID = 1'b0;
         end
      end
   endtask

   function automatic cfg_t rnd_cfg();
      int pst[5] = '{1, 3, 8, 16, 32};
      cfg_t c;
      c.d  = 8'($urandom);
      c.pe = 1'($urandom_range(0, 1));
      c.pt = 1'($urandom_range(0, 1));
      c.ps = 6'(pst[$urandom_range(0, 4)]);
      return c;
   endfunction

   cfg_t c, cur, nxt, none;
   bit   nv;

   initial begin
      none       = '0;
      rst_n      = 1'b0;
      DATA_VALID = 1'b0;
      apply(none);
      #12;
      chk("reset_tx", TX_OUT, 1'b1);
      chk("reset_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_chk("idle0");
      idle_chk("idle1");

      c = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd8};
      launch(c);
      frame(c, 1'b0, 1'b0, none);
      idle_chk("even_end");

      c.pt = 1'b1;
      launch(c);
      frame(c, 1'b0, 1'b0, none);
      idle_chk("odd_end");

      c.pe = 1'b0;
      launch(c);
      frame(c, 1'b0, 1'b0, none);
      idle_chk("nopar_end");

      c   = '{d: 8'h00, pe: 1'b1, pt: 1'b0, ps: 6'd16};
      nxt = '{d: 8'hFF, pe: 1'b0, pt: 1'b1, ps: 6'd16};
      launch(c);
      frame(c, 1'b1, 1'b1, nxt);
      frame(nxt, 1'b0, 1'b0, none);
      idle_chk("b2b_end");

      cur = rnd_cfg();
      launch(cur);
      for (int i = 0; i < 12; i++) begin
         nxt = rnd_cfg();
         nv  = (i < 11) ? bit'($urandom_range(0, 1)) : 1'b0;
         frame(cur, bit'($urandom_range(0, 1)), nv, nxt);
         if (!nv) begin
            idle_chk($sformatf("rnd%0d_end", i));
            if (i < 11)
               launch(nxt);
         end
         cur = nxt;
      end

      c = '{d: 8'h69, pe: 1'b1, pt: 1'b1, ps: 6'd0};
      launch(c);
      frame(c, 1'b0, 1'b0, none);
      idle_chk("ps0_end");

      c = '{d: 8'hF3, pe: 1'b1, pt: 1'b0, ps: 6'd8};
      launch(c);
      @(posedge clk);
      @(negedge clk);
      DATA_VALID = 1'b0;
      repeat (35) @(posedge clk);
      #1;
      chk("pre_rst_bit3", TX_OUT, c.d[3]);
      chk("pre_rst_busy", busy, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx", TX_OUT, 1'b1);
      chk("async_rst_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_chk("post_rst");
      c = '{d: 8'h5A, pe: 1'b1, pt: 1'b1, ps: 6'd8};
      launch(c);
      frame(c, 1'b0, 1'b0, none);
      idle_chk("clean_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
